// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and the digit clamp used on parallel loads.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_sync_par_down_cntr_if.sv
// Control/status bundle of the BCD down counter; the master drives the controls.
interface bcd_sync_par_down_cntr_if #(
  parameter int unsigned DIGITS = 2
);
  import bcd_pkg::*;

  logic                    cnt_en;
  logic                    load;
  logic [BCD_W*DIGITS-1:0] load_val;
  logic [BCD_W*DIGITS-1:0] count;
  logic                    borrow;
  logic                    ldnout;
  logic                    load_err;

  modport master (
    output cnt_en, load, load_val,
    input  count, borrow, ldnout, load_err
  );

  modport slave (
    input  cnt_en, load, load_val,
    output count, borrow, ldnout, load_err
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter: load > reload > decrement > hold.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_digit,
  input  logic             dec,
  input  logic             reload,
  input  logic [BCD_W-1:0] rl_digit,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = ld_digit;
    end else if (reload) begin
      digit_d = rl_digit;
    end else if (dec) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_sync_par_down_cntr.sv
// Presettable multi-digit BCD down counter with borrow look-ahead, cascade borrow
// and auto-reload (or wrap to all 9s) on underflow.
module bcd_sync_par_down_cntr
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter bit          AUTO_RELOAD = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  bcd_sync_par_down_cntr_if.slave       bus
);

  localparam int unsigned W = BCD_W * DIGITS;

  logic [W-1:0]      ld_clamped;
  logic [W-1:0]      count_w;
  logic [DIGITS-1:0] digit_bad;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS:0]   lower_zero;
  logic              underflow;

  logic [W-1:0]      preset_q, preset_d;
  logic              ldnout_q, ldnout_d;
  logic              load_err_q, load_err_d;

  // lower_zero[i] is the look-ahead borrow into digit i.
  assign lower_zero[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [BCD_W-1:0] rl_digit;

    assign ld_clamped[g*BCD_W +: BCD_W] = bcd_clamp(bus.load_val[g*BCD_W +: BCD_W]);
    assign digit_bad[g]     = (bus.load_val[g*BCD_W +: BCD_W] > BCD_MAX);
    assign lower_zero[g+1]  = lower_zero[g] & is_zero[g];
    assign rl_digit         = AUTO_RELOAD ? preset_q[g*BCD_W +: BCD_W] : BCD_MAX;

    bcd_down_digit u_digit (
      .clk      (clk),
      .rstn     (rstn),
      .load     (bus.load),
      .ld_digit (ld_clamped[g*BCD_W +: BCD_W]),
      .dec      (bus.cnt_en & lower_zero[g]),
      .reload   (underflow),
      .rl_digit (rl_digit),
      .digit    (count_w[g*BCD_W +: BCD_W]),
      .is_zero  (is_zero[g])
    );
  end

  assign underflow = bus.cnt_en & ~bus.load & lower_zero[DIGITS];

  always_comb begin
    preset_d   = preset_q;
    if (bus.load) begin
      preset_d = ld_clamped;
    end
    ldnout_d   = ~underflow;
    load_err_d = bus.load & (|digit_bad);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      preset_q   <= '0;
      ldnout_q   <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      preset_q   <= preset_d;
      ldnout_q   <= ldnout_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_w;
  assign bus.borrow   = underflow;
  assign bus.ldnout   = ldnout_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_sync_par_down_cntr.sv
// Bench: two 2-digit counters (reload / wrap) and a cascaded pair of 1-digit counters
// checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_sync_par_down_cntr;

  logic       clk = 1'b0;
  logic       rstn, cnt_en, load;
  logic [7:0] load_val;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  bcd_sync_par_down_cntr_if #(.DIGITS(2)) bus_a ();
  bcd_sync_par_down_cntr_if #(.DIGITS(2)) bus_w ();
  bcd_sync_par_down_cntr_if #(.DIGITS(1)) bus_lo ();
  bcd_sync_par_down_cntr_if #(.DIGITS(1)) bus_hi ();

  assign bus_a.cnt_en    = cnt_en;
  assign bus_a.load      = load;
  assign bus_a.load_val  = load_val;
  assign bus_w.cnt_en    = cnt_en;
  assign bus_w.load      = load;
  assign bus_w.load_val  = load_val;
  assign bus_lo.cnt_en   = cnt_en;
  assign bus_lo.load     = load;
  assign bus_lo.load_val = load_val[3:0];
  assign bus_hi.cnt_en   = bus_lo.borrow;
  assign bus_hi.load     = load;
  assign bus_hi.load_val = load_val[3:0];

  bcd_sync_par_down_cntr #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_a (
    .clk(clk), .rstn(rstn), .bus(bus_a));
  bcd_sync_par_down_cntr #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_w (
    .clk(clk), .rstn(rstn), .bus(bus_w));
  bcd_sync_par_down_cntr #(.DIGITS(1), .AUTO_RELOAD(1'b1)) u_lo (
    .clk(clk), .rstn(rstn), .bus(bus_lo));
  bcd_sync_par_down_cntr #(.DIGITS(1), .AUTO_RELOAD(1'b1)) u_hi (
    .clk(clk), .rstn(rstn), .bus(bus_hi));

  // Reference model: counts held as plain decimal integers.
  // Index 0 = u_a, 1 = u_w, 2 = u_lo, 3 = u_hi.
  int m_cnt [4];
  int m_pre [4];
  bit m_ldn [4];
  bit m_err [4];
  bit m_valid = 1'b0;

  function automatic int ndig(input int k);
    return (k < 2) ? 2 : 1;
  endfunction

  function automatic int max_val(input int k);
    return (ndig(k) == 2) ? 99 : 9;
  endfunction

  function automatic bit en_of(input int k);
    if (k < 3) return cnt_en;
    return cnt_en & ~load & (m_cnt[2] == 0);
  endfunction

  function automatic bit exp_borrow(input int k);
    return en_of(k) & ~load & (m_cnt[k] == 0);
  endfunction

  function automatic int clamp_val(input logic [7:0] lv, input int d);
    int v = 0;
    int mul = 1;
    for (int i = 0; i < d; i++) begin
      int n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v += n * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic bit any_bad(input logic [7:0] lv, input int d);
    bit b = 1'b0;
    for (int i = 0; i < d; i++) if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] obs_count(input int k);
    case (k)
      0:       return {24'b0, bus_a.count};
      1:       return {24'b0, bus_w.count};
      2:       return {28'b0, bus_lo.count};
      default: return {28'b0, bus_hi.count};
    endcase
  endfunction

  function automatic logic [2:0] obs_flags(input int k);
    case (k)
      0:       return {bus_a.borrow, bus_a.ldnout, bus_a.load_err};
      1:       return {bus_w.borrow, bus_w.ldnout, bus_w.load_err};
      2:       return {bus_lo.borrow, bus_lo.ldnout, bus_lo.load_err};
      default: return {bus_hi.borrow, bus_hi.ldnout, bus_hi.load_err};
    endcase
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit en [4];
    for (int k = 0; k < 4; k++) en[k] = en_of(k);
    for (int k = 0; k < 4; k++) begin
      if (!rstn) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_ldn[k] = 1'b1; m_err[k] = 1'b0;
      end else if (load) begin
        m_cnt[k] = clamp_val(load_val, ndig(k));
        m_pre[k] = m_cnt[k];
        m_ldn[k] = 1'b1;
        m_err[k] = any_bad(load_val, ndig(k));
      end else if (en[k]) begin
        m_err[k] = 1'b0;
        if (m_cnt[k] == 0) begin
          m_cnt[k] = (k == 1) ? max_val(k) : m_pre[k];
          m_ldn[k] = 1'b0;
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
          m_ldn[k] = 1'b1;
        end
      end else begin
        m_ldn[k] = 1'b1;
        m_err[k] = 1'b0;
      end
    end
    if (!rstn) m_valid = 1'b1;
  endtask

  task automatic cycle(input bit r, input bit l, input bit c, input logic [7:0] v);
    rstn = r; load = l; cnt_en = c; load_val = v;
    #1;
    if (m_valid)
      for (int k = 0; k < 4; k++)
        check("borrow", k, {31'b0, obs_flags(k)[2]}, {31'b0, exp_borrow(k)});
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 4; k++) begin
      check("count", k, obs_count(k), to_bcd(m_cnt[k]));
      check("ldnout", k, {31'b0, obs_flags(k)[1]}, {31'b0, m_ldn[k]});
      check("load_err", k, {31'b0, obs_flags(k)[0]}, {31'b0, m_err[k]});
    end
  endtask

  initial begin
    bit         r, l, c;
    logic [7:0] v;

    // Reset, then load 25 and count through a digit borrow.
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h25);
    repeat (6) cycle(1'b1, 1'b0, 1'b1, 8'h00);

    // Underflow: reload to 03 on u_a, wrap to 99 on u_w.
    cycle(1'b1, 1'b1, 1'b0, 8'h03);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 8'h00);

    // Clamped load, then a clean one.
    cycle(1'b1, 1'b1, 1'b0, 8'hA7);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h42);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Load beats count at 00; zero preset keeps underflowing.
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h00);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 8'h00);

    // Reset overrides load.
    cycle(1'b0, 1'b1, 1'b1, 8'h55);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Cascade from 11 through 00 and back to 11.
    cycle(1'b1, 1'b1, 1'b0, 8'h11);
    repeat (14) cycle(1'b1, 1'b0, 1'b1, 8'h00);

    // Randomised traffic.
    repeat (400) begin
      r = ($urandom_range(0, 49) != 0);
      l = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 3));
      else                           v = 8'($urandom);
      cycle(r, l, c, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
